// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg -- shared constants and types for the instruction fetch unit.
//   FETCH_FIFO_DEPTH : number of fetched words buffered ahead of decode
//   FETCH_PC_INCR    : byte increment between sequential fetches
//   fetch_entry_t    : buffered word {instruction, pc}
// Entry fields are sized for the widest supported configuration (32-bit
// instruction, 32-bit PC); narrower instances zero-extend on push and slice on
// read. Widening the fetch unit beyond 32 bits requires widening these fields.
package riscv_fetch_pkg;

   localparam int unsigned FETCH_FIFO_DEPTH    = 3;
   localparam int unsigned FETCH_PC_INCR       = 4;
   localparam int unsigned FETCH_CNT_W         = $clog2(FETCH_FIFO_DEPTH + 1);
   localparam int unsigned FETCH_ENTRY_INSTR_W = 32;
   localparam int unsigned FETCH_ENTRY_PC_W    = 32;

   typedef struct packed {
      logic [FETCH_ENTRY_INSTR_W-1:0] instruction;
      logic [FETCH_ENTRY_PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- FETCH_FIFO_DEPTH-entry buffer of fetched words.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write push_data_i (ignored when full and not popping)
//   pop_i          drop the head entry (ignored when empty)
//   flush_i        empty the buffer; overrides push and pop
//   push_data_i    entry to write
//   count_o        number of valid entries
//   head_o         oldest entry (contents meaningless when count_o == 0)
module fetch_fifo
   import riscv_fetch_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  fetch_entry_t           push_data_i,
   output logic [FETCH_CNT_W-1:0] count_o,
   output fetch_entry_t           head_o
);

   localparam int unsigned PTR_W = $clog2(FETCH_FIFO_DEPTH);

   fetch_entry_t           mem_q [FETCH_FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [FETCH_CNT_W-1:0] count_q, count_d;
   logic                   do_push, do_pop;

   // Depth is not a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FETCH_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FETCH_CNT_W'(FETCH_FIFO_DEPTH)) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + FETCH_CNT_W'(1);
            2'b01:   count_d = count_q - FETCH_CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch -- sequential instruction fetch with a 3-entry prefetch
// buffer in front of decode, driving a memory with one cycle read latency.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ImemAddress       read address to instruction memory
//   ImemInstruction   memory read data, one cycle after its address
//   Redirect          taken branch/jump: flush and refetch from RedirectTarget
//   RedirectTarget    new PC, sampled when Redirect = 1
//   InstrValid        Instruction/InstrPC hold a fetched word
//   InstrReady        decode accepts the word this cycle
//   Instruction       fetched word (buffer head)
//   InstrPC           address of Instruction
//   MisalignedFault   sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect to a
// non word-aligned target raises MisalignedFault and halts fetch until an
// aligned redirect or reset; when undefined the low target bits are dropped.
module instruction_fetch
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned              ADDRESS_WIDTH     = 9,
   parameter int unsigned              INSTRUCTION_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [ADDRESS_WIDTH-1:0]     ImemAddress,
   input  logic [INSTRUCTION_WIDTH-1:0] ImemInstruction,
   input  logic                         Redirect,
   input  logic [ADDRESS_WIDTH-1:0]     RedirectTarget,
   output logic                         InstrValid,
   input  logic                         InstrReady,
   output logic [INSTRUCTION_WIDTH-1:0] Instruction,
   output logic [ADDRESS_WIDTH-1:0]     InstrPC,
   output logic                         MisalignedFault
);

   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     inflight_q, inflight_d;
   logic                     halt, issue;
   logic [FETCH_CNT_W-1:0]   fifo_count;
   logic [FETCH_CNT_W:0]     occupancy;
   fetch_entry_t             push_entry, fifo_head;
   logic                     unused_head;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q, fault_d;

   // Every redirect re-evaluates the flag, so an aligned one clears it.
   always_comb begin
      fault_d = fault_q;
      if (Redirect) fault_d = (RedirectTarget[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end

   assign redirect_pc     = RedirectTarget;
   assign halt            = fault_q;
   assign MisalignedFault = fault_q;
`else
   assign redirect_pc     = RedirectTarget & ~ADDRESS_WIDTH'(3);
   assign halt            = 1'b0;
   assign MisalignedFault = 1'b0;
`endif

   // Issue only while every outstanding word is guaranteed a buffer slot.
   assign occupancy = (FETCH_CNT_W + 1)'(fifo_count) + (FETCH_CNT_W + 1)'(inflight_q);
   assign issue     = !Redirect && !halt &&
                      (occupancy < (FETCH_CNT_W + 1)'(FETCH_FIFO_DEPTH));

   assign ImemAddress = issue ? pc_q : last_addr_q;

   always_comb begin
      pc_d        = pc_q;
      last_addr_d = last_addr_q;
      inflight_d  = issue;
      if (Redirect) begin
         pc_d       = redirect_pc;
         inflight_d = 1'b0;
      end else if (issue) begin
         last_addr_d = pc_q;
         pc_d        = pc_q + ADDRESS_WIDTH'(FETCH_PC_INCR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         last_addr_q <= RESET_PC;
         inflight_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         last_addr_q <= last_addr_d;
         inflight_q  <= inflight_d;
      end
   end

   // The returning word belongs to the address issued last cycle, which is
   // exactly what last_addr_q holds while inflight_q is set.
   assign push_entry = '{instruction: FETCH_ENTRY_INSTR_W'(ImemInstruction),
                         pc:          FETCH_ENTRY_PC_W'(last_addr_q)};

   fetch_fifo u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .push_i      (inflight_q),
      .pop_i       (InstrValid && InstrReady),
      .flush_i     (Redirect),
      .push_data_i (push_entry),
      .count_o     (fifo_count),
      .head_o      (fifo_head)
   );

   assign InstrValid  = (fifo_count != '0);
   assign Instruction = InstrValid ? fifo_head.instruction[INSTRUCTION_WIDTH-1:0] : '0;
   assign InstrPC     = InstrValid ? fifo_head.pc[ADDRESS_WIDTH-1:0] : '0;
   assign unused_head = ^fifo_head;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 9, byte-address width of the instruction memory port and PC.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ImemAddress  output  ADDRESS_WIDTH  read address to instruction memory.
REQ-007 SHALL have port ImemInstruction  input  INSTRUCTION_WIDTH  memory read data, valid one cycle after its address.
REQ-008 SHALL have port Redirect  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port RedirectTarget  input  ADDRESS_WIDTH  new PC, sampled when Redirect=1.
REQ-010 SHALL have port InstrValid  output  1  Instruction/InstrPC hold a fetched word.
REQ-011 SHALL have port InstrReady  input  1  decode accepts the word this cycle.
REQ-012 SHALL have port Instruction  output  INSTRUCTION_WIDTH  fetched word (FIFO head).
REQ-013 SHALL have port InstrPC  output  ADDRESS_WIDTH  address of Instruction.
REQ-014 SHALL have port MisalignedFault  output  1  sticky misaligned-target flag.

Function
REQ-015 SHALL issue a fetch in a cycle by driving ImemAddress=PC when (FIFO count + in-flight) <= 2, then PC <= PC+4 modulo 2^ADDRESS_WIDTH (wraps, no error).
REQ-016 SHALL capture ImemInstruction with its PC into a 3-entry FIFO at the clock edge ending the cycle after issue; address-to-InstrValid latency is 2 cycles.
REQ-017 SHALL sustain one instruction per cycle when InstrReady stays 1.
REQ-018 SHALL transfer a word when InstrValid and InstrReady are both 1; Instruction/InstrPC SHALL stay stable while InstrValid=1 and InstrReady=0.
REQ-019 SHALL keep ImemAddress at the last issued address when not issuing.
REQ-020 SHALL, on Redirect=1, flush the FIFO, discard the in-flight response, set PC <= RedirectTarget, and issue the target in the next cycle; the target word is valid 3 cycles after the Redirect cycle.
REQ-021 SHALL count a handshake occurring in the Redirect cycle as completed; decode discards it.
REQ-022 SHALL give Redirect priority over issue, capture, and pop in the same cycle.
REQ-023 SHALL treat FIFO full with no in-flight fetch as no issue; capture and pop in the same cycle leave the count unchanged.

Reset
REQ-024 SHALL, while rst_n=0, hold PC=RESET_PC, ImemAddress=RESET_PC, FIFO empty, no in-flight fetch, InstrValid=0, Instruction=0, InstrPC=0, MisalignedFault=0.
REQ-025 SHALL make the first issue in the first cycle after rst_n deasserts; reset mid-operation SHALL drop all fetched and in-flight words.

Configuration
REQ-026 SHALL, with FETCH_MISALIGN_CHECK_EN defined, flag a Redirect with RedirectTarget[1:0]!=0 by setting MisalignedFault=1 one cycle later, flushing, and halting issue until an aligned Redirect or reset clears the flag.
REQ-027 SHALL, without FETCH_MISALIGN_CHECK_EN, force RedirectTarget[1:0] to 0 and tie MisalignedFault to 0.

Structure
REQ-028 SHALL place the FIFO depth constant (3), PC increment (4), and the FIFO entry struct {instruction, pc} in the shared package riscv_fetch_pkg.
REQ-029 SHALL implement the FIFO as the sub-module fetch_fifo (push, pop, flush, count, head).

Verification
REQ-030 SHALL verify: reset release with RESET_PC=0 and InstrReady=1 -> ImemAddress 0,4,8,... on consecutive cycles; InstrValid from cycle 2 with InstrPC 0,4,8 back-to-back.
REQ-031 SHALL verify: InstrReady=0 for 5 cycles -> FIFO fills to 3, issue stops, Instruction/InstrPC stay at PC 0; releasing InstrReady -> 0,4,8,12 in order with no loss or duplicate.
REQ-032 SHALL verify: Redirect with target 0x40 while FIFO holds 2 and 1 in flight -> InstrValid=0 in the next 2 cycles, ImemAddress=0x40 one cycle after Redirect, InstrPC=0x40 valid 3 cycles after.
REQ-033 SHALL verify: PC at 0x1FC with ADDRESS_WIDTH=9 -> next fetch address 0x000.
REQ-034 SHALL verify: with macro defined, Redirect target 0x42 -> MisalignedFault=1, no further issue; a Redirect to 0x80 clears it and fetching resumes. Without the macro, target 0x42 fetches from 0x40.
REQ-035 SHALL verify: rst_n asserted mid-stream with InstrValid=1 -> InstrValid=0 immediately; after release, fetch restarts at RESET_PC.
